spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
SPI master that runs complete register accesses against our 32x8 SPI register slave using its two-frame protocol. Each access is one command frame (nCS low, 8 bits) followed by one data frame (nCS low, 8 bits). The block sits in the system-clock domain between a local bus requester and the SPI pins. It generates nCS, SCLK and MOSI, and captures MISO.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (legal range 1 to 255)
CS_GAP, 2, minimum nCS-high time after each frame, in SCLK half-periods (legal range 1 to 15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only while busy=0
rw  input  1  1=read, 0=write; captured with start
addr  input  5  register address; captured with start
wdata  input  8  write data; captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the access completes
rdata  output  8  read result; updated at done for reads, held otherwise
nCS  output  1  SPI chip select, active low
SCLK  output  1  SPI clock, idle low
MOSI  output  1  SPI data out, MSB first
MISO  input  1  SPI data in

Behaviour:
- Reset values: nCS=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=8'h00. FSM returns to IDLE and the frame pointer returns to CMD.
- Command byte: {rw, 2'b00, addr}. Data byte: wdata for writes, 8'h00 for reads.
- Start handling: start is accepted when busy=0 and the FSM is in IDLE. rw, addr and wdata are latched on that cycle. A start pulse while busy=1 is ignored; no queueing.
- FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> (LEAD for the data frame | IDLE after the data frame).
- A single half-period counter (0..CLK_DIV-1) times every state. A bit counter (7..0) and a frame flag (CMD or DATA) qualify the transitions.
- LEAD (1 half-period): nCS=0, SCLK=0, MOSI = bit 7 of the current byte.
- SHIFT (16 half-periods):
  - SCLK toggles at the end of each half-period.
  - On each falling SCLK edge, MOSI advances to the next lower bit.
  - For reads in the DATA frame, MISO is sampled into a shift register on the system-clock cycle where SCLK goes 1->0. The slave updates MISO on the rising edge, so sample k (k=0..7) is rdata bit 7-k.
- SHIFT ends after the 8th falling edge. SCLK is 0 at exit.
- TRAIL (1 half-period): SCLK=0, nCS=0, MOSI held. At the end of TRAIL, nCS goes 1. This nCS rising edge supplies the slave's final internal clock edge (write strobe and address latch), so nCS must never rise while SCLK=1.
- GAP (CS_GAP half-periods): nCS=1, SCLK=0, MOSI=0.
  - After a CMD frame: switch to DATA and go to LEAD.
  - After a DATA frame: pulse done, load rdata (reads only), clear busy, go to IDLE.
- Latency: with D=CLK_DIV and G=CS_GAP, done is asserted exactly 2*(18+G)*D + 1 clk cycles after the start-accept cycle. busy is low in the cycle after done. A new start accepted in the done cycle's following cycle is legal.
- nCS always falls exactly twice per access (once per frame). The slave tracks its frame phase by counting nCS falling edges.
- Reset mid-access: all pins go to reset values immediately and asynchronously, and the partial access is discarded with no done pulse. The slave's phase tracking then becomes inconsistent, so the system must reset both ends together. This is a system requirement, not a function of this block.
- Width rules: counters are sized for the maximum legal parameters. No arithmetic on the data path.

Test Plan:
- Write: with CLK_DIV=2 and CS_GAP=2, issue start with rw=0, addr=5'h0A, wdata=8'hA5. Required: MOSI frame 1 = 8'h0A and frame 2 = 8'hA5, sampled on rising SCLK. Exactly 8 SCLK rising edges per frame. done at cycle 81 after accept. rdata unchanged.
- Read-back: after the write above, issue rw=1, addr=5'h0A against a slave model. Required: command byte 8'h8A, data-frame MOSI all 0, rdata=8'hA5 at done, busy low the next cycle.
- Back-to-back: write addr 5'h1F data 8'h3C, then start on the first cycle busy=0 with a read of addr 5'h1F. Required: nCS high for at least CS_GAP*CLK_DIV cycles between every pair of frames. Read returns 8'h3C.
- Start while busy: pulse start again mid-command-frame with different addr. Required: ignored; only one done; frame bytes unchanged.
- Reset mid-SHIFT: assert rst_n=0 while SCLK=1 in the data frame. Required: nCS=1, SCLK=0, MOSI=0, busy=0 asynchronously; no done; the next access after rst_n release starts with a correct command frame.
- CLK_DIV=1, CS_GAP=1: write 8'hFF to addr 5'h00. Required: SCLK period 2 clk, done at cycle 39, slave register 0 = 8'hFF.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI master running two-frame register accesses (command frame, then data frame)
// against the 32x8 SPI register slave; all timing derived from one half-period counter.
//
// state | meaning
// IDLE  | waiting for start; also clears busy the cycle after done
// LEAD  | nCS low, SCLK low, MOSI = bit 7, one half-period
// SHIFT | 16 half-periods, SCLK toggles, MOSI advances on falling edges
// TRAIL | SCLK low one half-period so nCS never rises with SCLK high
// GAP   | nCS high CS_GAP half-periods, then next frame or done
module spi_cmd_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nCS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_M1 = 4'(CS_GAP - 1);

    state_t     state_q;
    logic [7:0] div_q, div_d;
    logic       div_tc;
    logic [2:0] bit_q;
    logic [3:0] gap_q;
    logic       frame_q;
    logic       rw_q;
    logic [7:0] tx_q;
    logic [7:0] data_q;
    logic [7:0] rx_q;
    logic [7:0] rdata_q;
    logic       busy_q;
    logic       done_q;
    logic       ncs_q;
    logic       sclk_q;
    logic       mosi_q;

    assign div_tc = (div_q == 8'd0);

    always_comb begin
        div_d = div_q - 8'd1;
        if (state_q == IDLE || div_tc) begin
            div_d = DIV_M1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= DIV_M1;
            bit_q   <= 3'd7;
            gap_q   <= 4'd0;
            frame_q <= 1'b0;
            rw_q    <= 1'b0;
            tx_q    <= 8'h00;
            data_q  <= 8'h00;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div_q  <= div_d;
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (start) begin
                        busy_q  <= 1'b1;
                        rw_q    <= rw;
                        tx_q    <= {rw, 2'b00, addr};
                        data_q  <= rw ? 8'h00 : wdata;
                        frame_q <= 1'b0;
                        ncs_q   <= 1'b0;
                        mosi_q  <= rw;
                        state_q <= LEAD;
                    end
                end
                LEAD: begin
                    if (div_tc) begin
                        bit_q   <= 3'd7;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_tc) begin
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            // slave drives MISO on the rising edge, so the falling edge is safe
                            if (frame_q && rw_q) begin
                                rx_q <= {rx_q[6:0], MISO};
                            end
                            if (bit_q == 3'd0) begin
                                state_q <= TRAIL;
                            end else begin
                                bit_q  <= bit_q - 3'd1;
                                tx_q   <= {tx_q[6:0], 1'b0};
                                mosi_q <= tx_q[6];
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (div_tc) begin
                        ncs_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        gap_q   <= GAP_M1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (div_tc) begin
                        if (gap_q != 4'd0) begin
                            gap_q <= gap_q - 4'd1;
                        end else if (!frame_q) begin
                            frame_q <= 1'b1;
                            tx_q    <= data_q;
                            mosi_q  <= data_q[7];
                            ncs_q   <= 1'b0;
                            state_q <= LEAD;
                        end else begin
                            frame_q <= 1'b0;
                            done_q  <= 1'b1;
                            if (rw_q) begin
                                rdata_q <= rx_q;
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign nCS   = ncs_q;
    assign SCLK  = sclk_q;
    assign MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: instance 0 at CLK_DIV=2/CS_GAP=2, instance 1 at CLK_DIV=1/CS_GAP=1,
// each against a behavioural two-frame register slave that also logs frames and timing.
`timescale 1ns/1ps
module tb_spi_cmd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st[2], rw_i[2], bsy[2], dn[2], cs[2], sck[2], mo[2], mi[2];
    logic [4:0] ad[2];
    logic [7:0] wd[2], rd[2];

    int n_chk = 0;
    int n_fail = 0;

    spi_cmd_master #(.CLK_DIV(2), .CS_GAP(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .rw(rw_i[0]), .addr(ad[0]), .wdata(wd[0]),
        .busy(bsy[0]), .done(dn[0]), .rdata(rd[0]),
        .nCS(cs[0]), .SCLK(sck[0]), .MOSI(mo[0]), .MISO(mi[0]));

    spi_cmd_master #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .rw(rw_i[1]), .addr(ad[1]), .wdata(wd[1]),
        .busy(bsy[1]), .done(dn[1]), .rdata(rd[1]),
        .nCS(cs[1]), .SCLK(sck[1]), .MOSI(mo[1]), .MISO(mi[1]));

    // slave model and frame monitor, one process for both instances
    logic [7:0] mem [2][32] = '{default: '{default: 8'h00}};
    logic [7:0] fr_log [2][64];
    int         fr_edges [2][64];
    int         fr_n[2] = '{0, 0};
    int         done_n[2] = '{0, 0};
    int         gap_min[2] = '{1000, 1000};
    int         per_min[2] = '{1000, 1000};
    int         per_max[2] = '{0, 0};
    int         bad_rise[2] = '{0, 0};
    logic       pcs[2], psck[2], s_rw[2];
    logic [4:0] s_addr[2];
    logic [7:0] sh_in[2], sh_out[2];
    int         edges[2], falls[2], hi[2], last_rise[2];
    bit         have_rise[2];
    int         cyc = 0;

    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                pcs[g] = 1'b1; psck[g] = 1'b0; edges[g] = 0; falls[g] = 0;
                hi[g] = 0; have_rise[g] = 1'b0; mi[g] = 1'b0;
            end else begin
                if (dn[g]) done_n[g]++;
                if (pcs[g] && !cs[g]) begin
                    if (have_rise[g] && hi[g] < gap_min[g]) gap_min[g] = hi[g];
                    if (falls[g] % 2 == 1 && s_rw[g]) sh_out[g] = mem[g][s_addr[g]];
                    edges[g] = 0; sh_in[g] = 8'h00; falls[g]++;
                end
                if (!pcs[g] && cs[g]) begin
                    if (sck[g] || psck[g]) bad_rise[g]++;
                    if (fr_n[g] < 64) begin
                        fr_log[g][fr_n[g]] = sh_in[g];
                        fr_edges[g][fr_n[g]] = edges[g];
                        fr_n[g]++;
                    end
                    if (falls[g] % 2 == 1) begin
                        s_rw[g] = sh_in[g][7];
                        s_addr[g] = sh_in[g][4:0];
                    end else if (!s_rw[g]) begin
                        mem[g][s_addr[g]] = sh_in[g];
                    end
                    hi[g] = 0; have_rise[g] = 1'b1;
                end
                if (cs[g]) hi[g]++;
                if (!cs[g] && !psck[g] && sck[g]) begin
                    if (edges[g] > 0) begin
                        if (cyc - last_rise[g] < per_min[g]) per_min[g] = cyc - last_rise[g];
                        if (cyc - last_rise[g] > per_max[g]) per_max[g] = cyc - last_rise[g];
                    end
                    last_rise[g] = cyc;
                    sh_in[g] = {sh_in[g][6:0], mo[g]};
                    edges[g]++;
                    if (falls[g] % 2 == 0 && s_rw[g]) begin
                        mi[g] = sh_out[g][7];
                        sh_out[g] = {sh_out[g][6:0], 1'b0};
                    end
                end
                pcs[g] = cs[g]; psck[g] = sck[g];
            end
        end
    end

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h required %0h", tag, name, act, exp);
        end
    endtask

    task automatic chk_ge(input string tag, input string name, input int act, input int lim);
        n_chk++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d required at least %0d", tag, name, act, lim);
        end
    endtask

    task automatic run_access(input int g, input logic rw, input logic [4:0] a, input logic [7:0] w,
                              input logic poke, input int lat_exp, input logic [7:0] cmd_exp,
                              input logic [7:0] dat_exp, input logic [7:0] rd_exp, input string tag);
        int k, f0, d0;
        bit got;
        k = 0;
        while (bsy[g] && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, "idle", bsy[g], 1'b0);
        f0 = fr_n[g];
        d0 = done_n[g];
        st[g] = 1'b1; rw_i[g] = rw; ad[g] = a; wd[g] = w;
        @(negedge clk);
        st[g] = 1'b0; rw_i[g] = ~rw; ad[g] = ~a; wd[g] = ~w;
        got = 1'b0;
        k = 1;
        while (k <= lat_exp + 20) begin
            if (poke && k == 20) begin
                st[g] = 1'b1;
                ad[g] = a ^ 5'h11;
            end else begin
                st[g] = 1'b0;
            end
            if (dn[g]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        st[g] = 1'b0;
        chk(tag, "latency", got ? k : 0, lat_exp);
        chk(tag, "rdata", rd[g], rd_exp);
        @(negedge clk);
        chk(tag, "busy_after", bsy[g], 1'b0);
        chk(tag, "done_width", dn[g], 1'b0);
        chk(tag, "done_count", done_n[g] - d0, 1);
        chk(tag, "frames", fr_n[g] - f0, 2);
        chk(tag, "cmd_byte", fr_log[g][f0], cmd_exp);
        chk(tag, "data_byte", fr_log[g][f0 + 1], dat_exp);
        chk(tag, "edges", {fr_edges[g][f0][15:0], fr_edges[g][f0 + 1][15:0]}, {16'd8, 16'd8});
    endtask

    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic       poke;
        logic [7:0] cmd_exp;
        logic [7:0] dat_exp;
        logic [7:0] rd_exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, k;
        bit found;
        vt[0] = '{1'b0, 5'h0A, 8'hA5, 1'b0, 8'h0A, 8'hA5, 8'h00};
        vt[1] = '{1'b1, 5'h0A, 8'hFF, 1'b0, 8'h8A, 8'h00, 8'hA5};
        vt[2] = '{1'b0, 5'h1F, 8'h3C, 1'b1, 8'h1F, 8'h3C, 8'hA5};
        vt[3] = '{1'b1, 5'h1F, 8'h00, 1'b0, 8'h9F, 8'h00, 8'h3C};
        vt[4] = '{1'b0, 5'h15, 8'h5A, 1'b1, 8'h15, 8'h5A, 8'h3C};
        vt[5] = '{1'b1, 5'h15, 8'h00, 1'b1, 8'h95, 8'h00, 8'h5A};
        vt[6] = '{1'b1, 5'h0A, 8'h00, 1'b0, 8'h8A, 8'h00, 8'hA5};
        vt[7] = '{1'b0, 5'h00, 8'hC3, 1'b0, 8'h00, 8'hC3, 8'hA5};
        vt[8] = '{1'b1, 5'h00, 8'h00, 1'b0, 8'h80, 8'h00, 8'hC3};

        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            st[g] = 1'b0; rw_i[g] = 1'b0; ad[g] = 5'h00; wd[g] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("reset", "pins0", {cs[0], sck[0], mo[0], bsy[0], dn[0], rd[0]}, {5'b10000, 8'h00});
        chk("reset", "pins1", {cs[1], sck[1], mo[1], bsy[1], dn[1], rd[1]}, {5'b10000, 8'h00});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_access(0, vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].poke, 81,
                       vt[i].cmd_exp, vt[i].dat_exp, vt[i].rd_exp, $sformatf("vec%0d", i));
        end
        chk("d2", "slave_mem0A", mem[0][10], 8'hA5);
        chk_ge("d2", "cs_gap", gap_min[0], 4);
        chk("d2", "sclk_period", {per_min[0][15:0], per_max[0][15:0]}, {16'd4, 16'd4});
        chk("d2", "cs_rise_sclk_high", bad_rise[0], 0);

        // reset while SCLK is high in the data frame of a write
        f0 = fr_n[0];
        st[0] = 1'b1; rw_i[0] = 1'b0; ad[0] = 5'h03; wd[0] = 8'h77;
        @(negedge clk);
        st[0] = 1'b0;
        found = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fr_n[0] == f0 + 1 && !cs[0] && sck[0]) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid", "reach_shift", found, 1'b1);
        d0 = done_n[0];
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "async_pins", {cs[0], sck[0], mo[0], bsy[0]}, 4'b1000);
        repeat (4) @(negedge clk);
        chk("rst_mid", "no_done", done_n[0] - d0, 0);
        chk("rst_mid", "rdata", rd[0], 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid", "no_write", mem[0][3], 8'h00);
        run_access(0, 1'b0, 5'h03, 8'h77, 1'b0, 81, 8'h03, 8'h77, 8'h00, "post_rst_wr");
        run_access(0, 1'b1, 5'h03, 8'h00, 1'b0, 81, 8'h83, 8'h00, 8'h77, "post_rst_rd");

        run_access(1, 1'b0, 5'h00, 8'hFF, 1'b0, 39, 8'h00, 8'hFF, 8'h00, "d1_wr");
        chk("d1", "slave_mem00", mem[1][0], 8'hFF);
        chk("d1", "sclk_period", {per_min[1][15:0], per_max[1][15:0]}, {16'd2, 16'd2});
        chk_ge("d1", "cs_gap", gap_min[1], 1);
        chk("d1", "cs_rise_sclk_high", bad_rise[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
